ask_mod_gen: RTL and testbench
==============================

// Module: ask_mod_gen
// PURPOSE
//  Parametrised OOK/2-ASK modulator for the DAC path. Contains its own DDS (phase
//  accumulator + quarter-wave sine ROM) and a byte serializer with a baud counter.
//  It accepts bytes over a valid/ready handshake, shifts them out MSB first and
//  gates the carrier per bit. The output is unsigned offset-binary for the DA converter.
// PARAMETERS
//  DATA_W    8   output/sine sample width (offset binary, midscale = 2^(DATA_W-1))
//  PHASE_W   29  phase accumulator width; fcw = f_out*2^PHASE_W/f_clk
//  LUT_AW    8   full-cycle sine address bits (ROM holds 2^(LUT_AW-2) quarter entries)
//  SYM_BITS  8   bits per input word, sent MSB first
//  DIV_W     16  width of the baud divider
//  ATTEN_SH  2   ASK mode only: '0' symbol amplitude = full amplitude >> ATTEN_SH
// PORTS
//  clk        in   1         system clock
//  rst        in   1         reset: asynchronous assert, active-high
//  fcw        in   PHASE_W   carrier frequency word (21_474_836 = 2 MHz @ 50 MHz)
//  baud_div   in   DIV_W     clk cycles per bit; 0 is treated as 1
//  mode       in   1         0 = OOK, 1 = 2-level ASK
//  din        in   SYM_BITS  word to transmit
//  din_valid  in   1         din is valid
//  din_ready  out  1         block accepts din this cycle
//  busy       out  1         a word is being shifted out
//  bit_out    out  1         current bit, aligned with mod_out
//  mod_out    out  DATA_W    modulated sample to the DAC
// BEHAVIOUR
//  Reset (async, high): phase=0, FSM=IDLE, shift reg=0, baud cnt=0, din_ready=0,
//   busy=0, bit_out=0, mod_out=2^(DATA_W-1). din_ready first rises 1 clk after rst drops.
//  DDS: phase <= phase + fcw every clk, always running, wrapping mod 2^PHASE_W.
//   A new fcw is added starting the cycle after it is sampled. ROM address = phase top
//   LUT_AW bits. Quadrant mirroring/negation gives a signed sine s; ROM output is registered.
//  Carrier pipeline: phase reg -> ROM reg -> output mux reg. mod_out follows the phase by 2 clk.
//   The bit/mode gating is delayed by the same 2 stages so edges align with bit_out.
//  Output mux (registered): bit=1 -> mid+s; bit=0 & OOK -> mid; bit=0 & ASK ->
//   mid+(s>>>ATTEN_SH) (arithmetic shift). No valid path can saturate.
//  FSM states:
//   IDLE: din_ready=1, mod_out=mid, bit_out=0. When din_valid: load shreg<=din,
//    latch mode and baud_div (0->1), bitcnt<=SYM_BITS-1, cnt<=0, go to SEND.
//   SEND: busy=1, current bit = shreg MSB. cnt counts 0..div-1. At cnt=div-1: cnt<=0,
//    shift left. If bitcnt=0 the word is done, else bitcnt decrements.
//    din_ready=1 only in the final cycle of the last bit (cnt=div-1, bitcnt=0).
//    Valid in that cycle -> load the next word with no gap and stay in SEND.
//    Otherwise go to IDLE.
//  A handshake is din_valid & din_ready in the same clk. din is ignored at other times.
//  Each bit lasts exactly div clk. A word lasts exactly SYM_BITS*div clk at mod_out.
//  mode/baud_div changes mid-word take effect at the next word load only.
//  fcw changes take effect immediately, with a phase-continuous change (no phase reset).
//  Reset mid-word aborts the word. mod_out returns to midscale at once (async).
// TESTING
//  1 Reset: assert rst mid-word -> mod_out=128, busy=0, din_ready=0 on the same edge.
//    1 clk after release -> din_ready=1.
//  2 OOK 0xA5, baud_div=50, fcw=21_474_836, clk 50 MHz -> bit_out=1,0,1,0,0,1,0,1,
//    50 clk each. Carrier has 25 clk period during 1s. mod_out=128 during 0s. busy high 400 clk.
//  3 ASK 0x0F, ATTEN_SH=2 -> peak |mod_out-128| is ~127 on 1s and ~31 on 0s,
//    with no carrier phase jump at bit edges.
//  4 Back-to-back: din_valid held with 0x81 then 0x7E -> second handshake on the last
//    cycle of bit 0. No idle cycle between words. 16 bits, 800 clk total.
//  5 baud_div=0 and baud_div=1 -> 1 clk per bit. din_ready pulses every 8 clk while
//    din_valid is held.
//  6 fcw=2^(PHASE_W-2) -> period exactly 4 clk. Samples repeat mid, +max, mid, -max
//    (within 1 LSB). fcw=0 -> constant mod_out.

Source files
------------

// File: rtl/ask_mod_gen.sv
`default_nettype none
// ============================================================================
// Module   : ask_mod_gen
// Purpose  : OOK / 2-ASK modulator, DDS carrier gated by a baud-rate serializer.
// Revision : 1.0
// ============================================================================
module ask_mod_gen #(
  parameter int DATA_W   = 8,
  parameter int PHASE_W  = 29,
  parameter int LUT_AW   = 8,
  parameter int SYM_BITS = 8,
  parameter int DIV_W    = 16,
  parameter int ATTEN_SH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PHASE_W-1:0]  fcw,
  input  logic [DIV_W-1:0]    baud_div,
  input  logic                mode,
  input  logic [SYM_BITS-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic                busy,
  output logic                bit_out,
  output logic [DATA_W-1:0]   mod_out
);

  localparam int QAW = LUT_AW - 2;
  localparam int QN  = 2 ** QAW;
  localparam int BCW = (SYM_BITS > 1) ? $clog2(SYM_BITS) : 1;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  // Elaboration-time sine, Q30 fixed-point Taylor series over the first quadrant.
  function automatic longint sine_entry(input int k);
    longint x, x2, term, acc;
    x    = (64'sd6746518852 * longint'(k)) / longint'(2 ** LUT_AW);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      acc  = acc + term;
    end
    return (acc * longint'(2 ** (DATA_W - 1) - 1) + 64'sd536870912) >>> 30;
  endfunction

  logic [DATA_W-2:0] rom [QN];
  for (genvar k = 0; k < QN; k++) begin : g_rom
    localparam longint V = sine_entry(k);
    assign rom[k] = V[DATA_W-2:0];
  end

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [PHASE_W-1:0]        phase_q, phase_d;
  logic signed [DATA_W-1:0]  sine_q, sine_d;
  logic [SYM_BITS-1:0]       shreg_q, shreg_d;
  logic [DIV_W-1:0]          cnt_q, cnt_d, div_q, div_d;
  logic [BCW-1:0]            bitcnt_q, bitcnt_d;
  logic                      mode_q, mode_d;
  logic                      ready_q, ready_d, busy_q, busy_d;
  logic                      act_p1_q, act_p1_d, bit_p1_q, bit_p1_d, mode_p1_q, mode_p1_d;
  logic                      bit_out_q, bit_out_d;
  logic [DATA_W-1:0]         mod_out_q, mod_out_d;

  logic [LUT_AW-1:0]         addr;
  logic [QAW-1:0]            rom_idx;
  logic [DATA_W-1:0]         mag_ext;
  logic signed [DATA_W-1:0]  sine_sh;
  logic                      take;

  assign addr    = phase_q[PHASE_W-1 -: LUT_AW];
  assign rom_idx = addr[QAW] ? ~addr[QAW-1:0] : addr[QAW-1:0];
  assign mag_ext = {1'b0, rom[rom_idx]};
  assign sine_sh = sine_q >>> ATTEN_SH;
  assign take    = din_valid && ready_q;

  always_comb begin
    phase_d   = phase_q + fcw;
    sine_d    = addr[LUT_AW-1] ? -mag_ext : mag_ext;

    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bitcnt_d  = bitcnt_q;
    mode_d    = mode_q;

    if (state_q == SEND) begin
      if (cnt_q == div_q - 1'b1) begin
        cnt_d   = '0;
        shreg_d = shreg_q << 1;
        if (bitcnt_q == '0) state_d  = IDLE;
        else                bitcnt_d = bitcnt_q - 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // ready is only ever high in IDLE or the last cycle of a word, so a
    // handshake here is either a fresh start or a gapless follow-on word.
    if (take) begin
      state_d  = SEND;
      shreg_d  = din;
      mode_d   = mode;
      div_d    = (baud_div == '0) ? DIV_W'(1) : baud_div;
      bitcnt_d = BCW'(SYM_BITS - 1);
      cnt_d    = '0;
    end

    busy_d  = (state_d == SEND);
    ready_d = (state_d == IDLE) || ((cnt_d == div_d - 1'b1) && (bitcnt_d == '0));

    // Gating travels one stage here and one in the output register, matching
    // the phase -> ROM -> mux latency of the carrier.
    act_p1_d  = (state_q == SEND);
    bit_p1_d  = (state_q == SEND) && shreg_q[SYM_BITS-1];
    mode_p1_d = mode_q;
    bit_out_d = bit_p1_q;

    if (!act_p1_q)      mod_out_d = MID;
    else if (bit_p1_q)  mod_out_d = MID + sine_q;
    else if (!mode_p1_q) mod_out_d = MID;
    else                mod_out_d = MID + sine_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= '0;
      sine_q    <= '0;
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      div_q     <= DIV_W'(1);
      bitcnt_q  <= '0;
      mode_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      act_p1_q  <= 1'b0;
      bit_p1_q  <= 1'b0;
      mode_p1_q <= 1'b0;
      bit_out_q <= 1'b0;
      mod_out_q <= MID;
    end else begin
      phase_q   <= phase_d;
      sine_q    <= sine_d;
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bitcnt_q  <= bitcnt_d;
      mode_q    <= mode_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      act_p1_q  <= act_p1_d;
      bit_p1_q  <= bit_p1_d;
      mode_p1_q <= mode_p1_d;
      bit_out_q <= bit_out_d;
      mod_out_q <= mod_out_d;
    end
  end

  assign din_ready = ready_q;
  assign busy      = busy_q;
  assign bit_out   = bit_out_q;
  assign mod_out   = mod_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ask_mod_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ask_mod_gen
// Purpose  : Directed self-checking bench for ask_mod_gen (default parameters).
// Revision : 1.0
// ============================================================================
module tb_ask_mod_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [28:0] fcw = 29'd21474836;
  logic [15:0] baud_div = 16'd50;
  logic        mode = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_ready, busy, bit_out;
  logic [7:0]  mod_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_s  [0:1023];
  logic       b_s  [0:1023];
  logic       bz_s [0:1023];
  logic       rd_s [0:1023];

  ask_mod_gen dut (
    .clk       (clk),
    .rst       (rst),
    .fcw       (fcw),
    .baud_div  (baud_div),
    .mode      (mode),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .bit_out   (bit_out),
    .mod_out   (mod_out)
  );

  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; returns at the first negedge after the handshake edge.
  task automatic start_word(input logic [7:0] d, output bit ok);
    din       = d;
    din_valid = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (din_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic capture(input int n, input int drop_at);
    for (int j = 0; j < n; j++) begin
      if (j == drop_at) din_valid = 1'b0;
      m_s[j]  = mod_out;
      b_s[j]  = bit_out;
      bz_s[j] = busy;
      rd_s[j] = din_ready;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (mod_out !== 8'd128) $display("FAIL rst_mod_out: got %0d, required 128", mod_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
    n_checks++; if (din_ready !== 1'b0) $display("FAIL rst_ready: got %b, required 0", din_ready); else n_pass++;
    n_checks++; if (bit_out !== 1'b0) $display("FAIL rst_bit_out: got %b, required 0", bit_out); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (din_ready !== 1'b0) $display("FAIL rst_ready_release: got %b, required 0", din_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (din_ready !== 1'b1) $display("FAIL rst_ready_1clk: got %b, required 1", din_ready); else n_pass++;
  endtask

  task automatic test_ook;
    bit ok;
    int good, bad, bcnt, mx, mn, d;
    logic [7:0] w;
    logic e;
    w = 8'hA5;
    fcw = 29'd21474836; baud_div = 16'd50; mode = 1'b0;
    start_word(w, ok);
    n_checks++; if (!ok) $display("FAIL ook_handshake: no handshake, required one"); else n_pass++;
    capture(420, 0);
    for (int k = 0; k < 8; k++) begin
      good = 0;
      for (int j = 2 + 50 * k; j < 52 + 50 * k; j++) if (b_s[j] === w[7-k]) good++;
      n_checks++;
      if (good != 50) $display("FAIL ook_bit%0d: %0d of 50 samples matched, required 50", k, good); else n_pass++;
    end
    bad = 0;
    for (int j = 0; j < 420; j++) begin
      e = (j >= 2 && j < 402) ? w[7 - (j - 2) / 50] : 1'b0;
      if (e == 1'b0 && m_s[j] !== 8'd128) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL ook_zero_mid: %0d off-mid samples, required 0", bad); else n_pass++;
    bad = 0;
    for (int j = 2; j < 27; j++) begin
      d = int'(m_s[j]) - int'(m_s[j+25]);
      if (d < 0) d = -d;
      if (d > 4) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL ook_period25: %0d samples differ, required 0", bad); else n_pass++;
    mx = 0; mn = 255;
    for (int j = 2; j < 52; j++) begin
      if (int'(m_s[j]) > mx) mx = int'(m_s[j]);
      if (int'(m_s[j]) < mn) mn = int'(m_s[j]);
    end
    n_checks++;
    if (mx < 250 || mn > 6) $display("FAIL ook_swing: max %0d min %0d, required >=250 and <=6", mx, mn); else n_pass++;
    bcnt = 0;
    for (int j = 0; j < 420; j++) if (bz_s[j] === 1'b1) bcnt++;
    n_checks++; if (bcnt != 400) $display("FAIL ook_busy_len: got %0d, required 400", bcnt); else n_pass++;
    n_checks++; if (bz_s[400] !== 1'b0) $display("FAIL ook_busy_end: got %b, required 0", bz_s[400]); else n_pass++;
  endtask

  task automatic test_ask;
    bit ok;
    int pk0, pk1, d, d1, bad;
    fcw = 29'd21474836; baud_div = 16'd50; mode = 1'b1;
    start_word(8'h0F, ok);
    n_checks++; if (!ok) $display("FAIL ask_handshake: no handshake, required one"); else n_pass++;
    capture(420, 0);
    pk0 = 0; pk1 = 0;
    for (int j = 2; j < 402; j++) begin
      d = int'(m_s[j]) - 128;
      if (d < 0) d = -d;
      if (j < 202) begin if (d > pk0) pk0 = d; end
      else         begin if (d > pk1) pk1 = d; end
    end
    n_checks++; if (pk0 < 30 || pk0 > 32) $display("FAIL ask_peak0: got %0d, required 30..32", pk0); else n_pass++;
    n_checks++; if (pk1 < 125 || pk1 > 127) $display("FAIL ask_peak1: got %0d, required 125..127", pk1); else n_pass++;
    bad = 0;
    for (int j = 192; j < 202; j++) begin
      d  = 4 * (int'(m_s[j]) - 128);
      d1 = int'(m_s[j+25]) - 128;
      d  = d - d1;
      if (d < 0) d = -d;
      if (d > 10) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL ask_phase_cont: %0d samples jumped, required 0", bad); else n_pass++;
    n_checks++; if (b_s[2] !== 1'b0 || b_s[202] !== 1'b1) $display("FAIL ask_bits: got %b%b, required 01", b_s[2], b_s[202]); else n_pass++;
    mode = 1'b0;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int first, bad, bcnt;
    logic [15:0] w;
    w = 16'h817E;
    fcw = 29'd21474836; baud_div = 16'd50; mode = 1'b0;
    start_word(8'h81, ok);
    din = 8'h7E;
    n_checks++; if (!ok) $display("FAIL b2b_handshake: no handshake, required one"); else n_pass++;
    capture(820, 400);
    first = -1;
    for (int j = 0; j < 820; j++) if (first < 0 && rd_s[j] === 1'b1) first = j;
    n_checks++; if (first != 399) $display("FAIL b2b_ready_pos: got %0d, required 399", first); else n_pass++;
    bad = 0;
    for (int j = 2; j < 802; j++) if (b_s[j] !== w[15 - (j - 2) / 50]) bad++;
    n_checks++; if (bad != 0) $display("FAIL b2b_bits: %0d wrong samples, required 0", bad); else n_pass++;
    bcnt = 0;
    for (int j = 0; j < 800; j++) if (bz_s[j] === 1'b1) bcnt++;
    n_checks++; if (bcnt != 800) $display("FAIL b2b_busy: got %0d, required 800", bcnt); else n_pass++;
    n_checks++; if (bz_s[800] !== 1'b0) $display("FAIL b2b_busy_end: got %b, required 0", bz_s[800]); else n_pass++;
  endtask

  task automatic test_fast_baud;
    bit ok;
    int bad, bcnt;
    logic [7:0] w;
    w = 8'hC3;
    for (int bd = 0; bd < 2; bd++) begin
      baud_div = 16'(bd); mode = 1'b0;
      start_word(w, ok);
      n_checks++; if (!ok) $display("FAIL fast%0d_handshake: no handshake, required one", bd); else n_pass++;
      capture(40, 24);
      bad = 0;
      for (int j = 0; j < 31; j++) if (rd_s[j] !== ((j % 8) == 7)) bad++;
      n_checks++; if (bad != 0) $display("FAIL fast%0d_ready: %0d wrong samples, required 0", bd, bad); else n_pass++;
      bad = 0;
      for (int j = 2; j < 34; j++) if (b_s[j] !== w[7 - ((j - 2) % 8)]) bad++;
      n_checks++; if (bad != 0) $display("FAIL fast%0d_bits: %0d wrong samples, required 0", bd, bad); else n_pass++;
      bcnt = 0;
      for (int j = 0; j < 40; j++) if (bz_s[j] === 1'b1) bcnt++;
      n_checks++; if (bcnt != 32) $display("FAIL fast%0d_busy: got %0d, required 32", bd, bcnt); else n_pass++;
    end
    baud_div = 16'd50;
  endtask

  task automatic test_reset_midword;
    bit ok;
    fcw = 29'd21474836; baud_div = 16'd50; mode = 1'b0;
    start_word(8'hFF, ok);
    capture(30, 0);
    n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_pre_busy: got %b, required 1", busy); else n_pass++;
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (mod_out !== 8'd128) $display("FAIL rstmid_mod_out: got %0d, required 128", mod_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b, required 0", busy); else n_pass++;
    n_checks++; if (din_ready !== 1'b0) $display("FAIL rstmid_ready: got %b, required 0", din_ready); else n_pass++;
    fcw = 29'd1 << 27;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (din_ready !== 1'b0) $display("FAIL rstmid_ready_release: got %b, required 0", din_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (din_ready !== 1'b1) $display("FAIL rstmid_ready_1clk: got %b, required 1", din_ready); else n_pass++;
  endtask

  // Phase restarted at 0 with fcw = 2^27, so samples land exactly on quadrants.
  task automatic test_quarter_and_zero_fcw;
    bit ok;
    int j0, bad, d, ex;
    int pat [4];
    pat[0] = 255; pat[1] = 128; pat[2] = 1; pat[3] = 128;
    baud_div = 16'd50; mode = 1'b0;
    start_word(8'hFF, ok);
    capture(200, 0);
    j0 = -1;
    for (int j = 2; j < 6; j++) if (j0 < 0 && m_s[j] >= 8'd254) j0 = j;
    n_checks++; if (j0 < 0) $display("FAIL quarter_peak: no +max sample in first period, required one"); else n_pass++;
    bad = 0;
    if (j0 >= 0) begin
      for (int j = 2; j < 200; j++) begin
        ex = pat[(j - j0 + 8) % 4];
        d  = int'(m_s[j]) - ex;
        if (d < -1 || d > 1) bad++;
      end
    end
    n_checks++; if (bad != 0 || j0 < 0) $display("FAIL quarter_pattern: %0d wrong samples, required 0", bad); else n_pass++;
    fcw = '0;
    capture(100, -1);
    bad = 0;
    for (int j = 6; j < 100; j++) if (m_s[j] !== m_s[5]) bad++;
    n_checks++; if (bad != 0) $display("FAIL zero_fcw_const: %0d changed samples, required 0", bad); else n_pass++;
    capture(120, -1);
    n_checks++; if (busy !== 1'b0) $display("FAIL quarter_done: busy %b, required 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ook();
    test_ask();
    test_back_to_back();
    test_fast_baud();
    test_reset_midword();
    test_quarter_and_zero_fcw();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
